// File: rtl/i2c_shift_reg.sv
// i2c_shift_reg
// WIDTH-bit serial/parallel shift register with a shift counter and a
// one-cycle completion pulse. It serialises transmit bytes and assembles
// received bytes between the I2C byte controller and the SDA bit engine.
//
// Ports
//   Clock     sole clock, rising edge
//   Clear     synchronous active-high reset (highest priority)
//   Load      parallel load strobe, restarts a transfer
//   ParIn     parallel load data
//   Shift     shift-one-bit strobe, level sampled
//   SerIn     serial data in
//   ParOut    current register contents
//   SerOut    bit that leaves the register on the next shift
//   BitCount  shifts taken since last Load or completion
//   Busy      transfer in progress (also the FSM state: 0 IDLE, 1 SHIFTING)
//   Done      one-cycle pulse after the WIDTH-th shift
//
// Strobe semantics: Load and Shift are plain level-sampled commands with no
// ready/backpressure; the block accepts one command on every rising edge.
// Priority each edge is Clear > Load > Shift > hold.
module i2c_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                       Clock,
  input  logic                       Clear,
  input  logic                       Load,
  input  logic [WIDTH-1:0]           ParIn,
  input  logic                       Shift,
  input  logic                       SerIn,
  output logic [WIDTH-1:0]           ParOut,
  output logic                       SerOut,
  output logic [$clog2(WIDTH+1)-1:0] BitCount,
  output logic                       Busy,
  output logic                       Done
);

  localparam int CW = $clog2(WIDTH + 1);

  // FSM encoding; the state register is exported directly as Busy.
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_SHIFTING = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data;
  logic [CW-1:0]    cnt;
  logic [0:0]       state;
  logic             done;
  logic [WIDTH-1:0] data_shifted;

  // Shift toward MSB (I2C order) or toward LSB, new bit enters at the far end.
  always_comb begin
    data_shifted = data;
    if (MSB_FIRST != 0) begin
      data_shifted = {data[WIDTH-2:0], SerIn};
    end else begin
      data_shifted = {SerIn, data[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      data  <= '0;
      cnt   <= '0;
      state <= ST_IDLE;
      done  <= 1'b0;
    end else if (Load) begin
      data  <= ParIn;
      cnt   <= '0;
      state <= ST_SHIFTING;
      done  <= 1'b0;
    end else if (Shift) begin
      data <= data_shifted;
      // Counter wraps at WIDTH-1 so back-to-back transfers pulse Done
      // every WIDTH cycles with no idle gap.
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        state <= ST_IDLE;
        done  <= 1'b1;
      end else begin
        cnt   <= cnt + CW'(1);
        state <= ST_SHIFTING;
        done  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign ParOut   = data;
  assign SerOut   = (MSB_FIRST != 0) ? data[WIDTH-1] : data[0];
  assign BitCount = cnt;
  assign Busy     = (state == ST_SHIFTING);
  assign Done     = done;

endmodule
